// File: rtl/pct_playback_pkg.sv
// Shared encodings and defaults for the serial playback buffer.
package pct_playback_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int GAP_ZEROS_DEF = 96;
    localparam int HDR_BYTES     = 2;

    // One load state per header byte plus the data phase.
    typedef enum logic [$clog2(HDR_BYTES+1)-1:0] {
        LD_HDR_MSB,
        LD_HDR_LSB,
        LD_DATA
    } ld_state_t;

    typedef enum logic [2:0] {
        PL_IDLE,
        PL_LEAD,
        PL_DATA,
        PL_TRAIL,
        PL_DONE
    } pl_state_t;

endpackage

// File: rtl/playback_ram.sv
// Single-clock simple dual-port byte RAM: write port A, registered read port B.
module playback_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_playback_buffer.sv
// Loads a length-prefixed packet from the UART into RAM and replays it as a
// zero-framed MSB-first serial stream, emulating a front-end board.
module serial_playback_buffer
    import pct_playback_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int GAP_ZEROS = GAP_ZEROS_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RxD_data_ready,
    input  logic [7:0] RxD_data,
    input  logic       PlayStart,
    output logic       SerialDataOut,
    output logic       LoadDone,
    output logic       PlayDone,
    output logic       Loaded,
    output logic       Busy,
    output logic       RxDropped
);

    localparam int              GAP_W    = $clog2(GAP_ZEROS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_ZEROS - 1);

    ld_state_t         ld_q;
    pl_state_t         pl_q;
    logic [7:0]        hdr_msb_q;
    logic [ADDR_W-1:0] ncnt_q, wr_adr_q, rd_adr_q;
    logic [2:0]        bit_q;
    logic [GAP_W-1:0]  gap_q;
    logic              serial_q, load_done_q, play_done_q, loaded_q, busy_q, rx_drop_q;

    logic              play_accept, rx_take, last_byte, ram_we, ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [7:0]        rd_data;

    function automatic logic [ADDR_W-1:0] sat_len(input logic [7:0] msb, input logic [7:0] lsb);
        logic [31:0] hdr, cap;
        hdr = {16'd0, msb, lsb};
        cap = (32'd1 << ADDR_W) - 32'd1;
        return (hdr > cap) ? cap[ADDR_W-1:0] : hdr[ADDR_W-1:0];
    endfunction

    assign play_accept = PlayStart && (pl_q == PL_IDLE) && loaded_q && (ld_q == LD_HDR_MSB);
    assign rx_take     = RxD_data_ready && !busy_q && !play_accept;
    assign last_byte   = (rd_adr_q == ncnt_q - ADDR_W'(1));
    assign ram_we      = rx_take && (ld_q == LD_DATA);

    // Prefetch: byte 0 during the lead gap, the next byte while bit 0 is shifted out.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = rd_adr_q;
        if (pl_q == PL_LEAD) begin
            ram_re = 1'b1;
        end else if (pl_q == PL_DATA && bit_q == 3'd0 && !last_byte) begin
            ram_re    = 1'b1;
            ram_raddr = rd_adr_q + ADDR_W'(1);
        end
    end

    playback_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we),
        .waddr_i (wr_adr_q),
        .wdata_i (RxD_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ld_q        <= LD_HDR_MSB;
            loaded_q    <= 1'b0;
            load_done_q <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            rx_drop_q   <= RxD_data_ready && !rx_take;
            if (rx_take) begin
                case (ld_q)
                    LD_HDR_MSB: begin
                        loaded_q  <= 1'b0;
                        hdr_msb_q <= RxD_data;
                        ld_q      <= LD_HDR_LSB;
                    end
                    LD_HDR_LSB: begin
                        ncnt_q   <= sat_len(hdr_msb_q, RxD_data);
                        wr_adr_q <= '0;
                        if ({hdr_msb_q, RxD_data} == 16'd0) begin
                            load_done_q <= 1'b1;
                            loaded_q    <= 1'b1;
                            ld_q        <= LD_HDR_MSB;
                        end else begin
                            ld_q <= LD_DATA;
                        end
                    end
                    LD_DATA: begin
                        if (wr_adr_q == ncnt_q - ADDR_W'(1)) begin
                            load_done_q <= 1'b1;
                            loaded_q    <= 1'b1;
                            ld_q        <= LD_HDR_MSB;
                        end else begin
                            wr_adr_q <= wr_adr_q + ADDR_W'(1);
                        end
                    end
                    default: ld_q <= LD_HDR_MSB;
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pl_q        <= PL_IDLE;
            serial_q    <= 1'b0;
            busy_q      <= 1'b0;
            play_done_q <= 1'b0;
        end else begin
            play_done_q <= 1'b0;
            case (pl_q)
                PL_IDLE: begin
                    if (play_accept) begin
                        rd_adr_q <= '0;
                        if (ncnt_q == '0) begin
                            play_done_q <= 1'b1;
                        end else begin
                            pl_q   <= PL_LEAD;
                            busy_q <= 1'b1;
                            gap_q  <= GAP_LAST;
                        end
                    end
                end
                PL_LEAD: begin
                    if (gap_q == '0) begin
                        serial_q <= rd_data[7];
                        bit_q    <= 3'd6;
                        pl_q     <= PL_DATA;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                PL_DATA: begin
                    serial_q <= rd_data[bit_q];
                    bit_q    <= bit_q - 3'd1;
                    if (bit_q == 3'd0) begin
                        if (last_byte) begin
                            pl_q  <= PL_TRAIL;
                            gap_q <= GAP_LAST;
                        end else begin
                            rd_adr_q <= rd_adr_q + ADDR_W'(1);
                        end
                    end
                end
                PL_TRAIL: begin
                    serial_q <= 1'b0;
                    if (gap_q == '0) begin
                        pl_q <= PL_DONE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                PL_DONE: begin
                    busy_q      <= 1'b0;
                    play_done_q <= 1'b1;
                    pl_q        <= PL_IDLE;
                end
                default: pl_q <= PL_IDLE;
            endcase
        end
    end

    assign SerialDataOut = serial_q;
    assign LoadDone      = load_done_q;
    assign PlayDone      = play_done_q;
    assign Loaded        = loaded_q;
    assign Busy          = busy_q;
    assign RxDropped     = rx_drop_q;

endmodule
